// File: rtl/adder_pipe_nb.sv
// Pipelined add/subtract unit: one CHUNK-bit slice resolved per stage, carry registered between
// stages, valid/ready on both sides with a global stall.
module adder_pipe_nb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned Last   = STAGES - 1;
  localparam int unsigned Msb    = WIDTH - 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("adder_pipe_nb: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  // Per-stage state: partial sum, carry, operands still to be consumed, valid.
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic              carry_q [STAGES];

  // Inputs seen by each stage this cycle and the values it would register.
  logic [STAGES-1:0] valid_src;
  logic [WIDTH-1:0]  a_src     [STAGES];
  logic [WIDTH-1:0]  b_src     [STAGES];
  logic [WIDTH-1:0]  sum_src   [STAGES];
  logic              carry_src [STAGES];
  logic [CHUNK:0]    slice     [STAGES];
  logic [WIDTH-1:0]  sum_d     [STAGES];
  logic              carry_d   [STAGES];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign advance    = !valid_q[Last] || out_ready_i;
  assign in_ready_o = advance;
  assign b_eff      = sub_i ? ~b_i : b_i;
  assign cin_eff    = sub_i | cin_i;

  always_comb begin
    valid_src = '0;
    a_src     = '{default: '0};
    b_src     = '{default: '0};
    sum_src   = '{default: '0};
    carry_src = '{default: 1'b0};
    slice     = '{default: '0};
    sum_d     = '{default: '0};
    carry_d   = '{default: 1'b0};

    valid_src[0] = in_valid_i;
    a_src[0]     = a_i;
    b_src[0]     = b_eff;
    carry_src[0] = cin_eff;
    for (int k = 1; k < STAGES; k++) begin
      valid_src[k] = valid_q[k-1];
      a_src[k]     = a_q[k-1];
      b_src[k]     = b_q[k-1];
      sum_src[k]   = sum_q[k-1];
      carry_src[k] = carry_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]} + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
               + (CHUNK+1)'(carry_src[k]);
      sum_d[k] = sum_src[k];
      sum_d[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
      carry_d[k] = slice[k][CHUNK];
    end
  end

  // Data registers only load for real transfers so bubbles do not toggle the datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
    end else if (advance) begin
      valid_q <= valid_src;
      for (int k = 0; k < STAGES; k++) begin
        if (valid_src[k]) begin
          a_q[k]     <= a_src[k];
          b_q[k]     <= b_src[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
    end
  end

  assign out_valid_o = valid_q[Last];
  assign sum_o       = sum_q[Last];
  assign cout_o      = carry_q[Last];
  assign ovf_o       = (a_q[Last][Msb] == b_q[Last][Msb]) && (sum_q[Last][Msb] != a_q[Last][Msb]);
  // Gated by valid so the idle/reset output reads zero=0 rather than reflecting a cleared sum.
  assign zero_o      = valid_q[Last] && (sum_q[Last] == '0);

endmodule
